y86_instr_encoder: RTL
======================

Name: y86_instr_encoder

Overview:
- Writer-side counterpart to the SEQ fetch stage: accepts decoded Y86 instruction fields and serialises them, one byte per cycle, into the byte-wide instruction memory that fetch later reads.
- Used by test/loader infrastructure to build programs in memory instead of hand-coding memory_chunk bytes.
- Byte layout and instruction lengths match what fetch decodes.

Parameters:
ADDR_W, 10, byte-address width of instruction memory
MEM_DEPTH, 1024, number of addressable bytes
BASE_ADDR, 0, address of first byte written after reset

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction fields valid
in_ready  output  1  encoder can accept an instruction
in_code  input  4  icode
in_fun  input  4  ifun
ra  input  4  rA field
rb  input  4  rB field
val_c  input  64  constant/destination
mem_we  output  1  byte write strobe
mem_addr  output  ADDR_W  byte write address
mem_wdata  output  8  byte write data
wr_ptr  output  ADDR_W  next free byte address
instr_count  output  16  instructions fully written
in_error  output  1  sticky: illegal icode received
bad_mem  output  1  sticky: instruction would exceed memory
flag_halt  output  1  sticky: halt instruction written

Behaviour:
- Reset (async, reset_n=0) values: in_ready=0 while reset is asserted, then 1 from the first clock after release. mem_we=0, mem_addr=0, mem_wdata=0, wr_ptr=BASE_ADDR, instr_count=0, in_error=0, bad_mem=0, flag_halt=0. FSM=IDLE.
- Clock and reset: one clock; reset is asynchronous and active-low (clock, reset_n).
- Length table (LEN):
  - icode 0, 1, 9: 1 byte
  - icode 2, 6, 10, 11: 2 bytes
  - icode 3, 4, 5: 10 bytes
  - icode 7, 8: 9 bytes
- Byte order:
  - byte0 = {in_code, in_fun}.
  - 2-byte and 10-byte forms: byte1 = {ra, rb}.
  - 10-byte forms: bytes 2..9 = val_c, MSB first (big-endian).
  - 9-byte forms: bytes 1..8 = val_c, MSB first.
- FSM states: IDLE, EMIT, STOP.
- IDLE:
  - in_ready=1. Accept on in_valid & in_ready at cycle T; latch all fields.
  - in_code>11: in_error=1 at T+1, no writes, go to STOP.
  - wr_ptr+LEN > MEM_DEPTH (computed ADDR_W+1 bits wide): bad_mem=1 at T+1, no writes, go to STOP.
  - Otherwise go to EMIT with byte index k=0.
- EMIT:
  - in_ready=0.
  - Cycle T+1+k: mem_we=1, mem_addr=wr_ptr+k, mem_wdata=byte k. Runs for k=0..LEN-1.
  - On the last byte: wr_ptr += LEN and instr_count += 1 (both visible at T+LEN+1).
  - If in_code==0, set flag_halt=1 and go to STOP; otherwise return to IDLE.
  - in_ready is high again at T+LEN+1.
- STOP: in_ready=0 and mem_we=0 until reset. Inputs are ignored.
- mem_we is low in every cycle not listed above. mem_addr and mem_wdata hold their last values when idle.
- Writing exactly up to address MEM_DEPTH-1 is legal; wr_ptr may then equal MEM_DEPTH mod 2^ADDR_W. Any further non-zero-length instruction raises bad_mem.
- instr_count wraps at 2^16.
- Reset mid-EMIT: abandon immediately. Already-written bytes stay in memory; wr_ptr returns to BASE_ADDR.
- in_valid while in_ready=0 is ignored; the source must hold its fields until accepted.

Optional Feature:
ENCODER_CHECKSUM_EN
- Defined:
  - Adds output port checksum (8-bit) = modulo-256 sum of every byte written since reset.
  - Updated the cycle after each mem_we; reset value 0.
  - Unaffected by rejected instructions.
- Undefined: port and adder absent; all other behaviour identical.

Test Plan:
- irmovq: in_code=3, in_fun=0, ra=F, rb=2, val_c=0x10 at BASE_ADDR=0 -> bytes 0x30,0xF2,0x00×7,0x10 at addr 0..9 in 10 consecutive cycles; then wr_ptr=10, instr_count=1, in_ready=1.
- Mixed stream: jmp 39 (7/0, val_c=0x27) then addq %rax,%rbx (6/0, ra=0, rb=3) then halt -> 0x70,0x00×7,0x27 at 0..8; 0x60,0x03 at 9..10; 0x00 at 11; flag_halt=1, in_ready stuck 0, instr_count=3.
- Illegal icode: in_code=12 -> in_error=1 next cycle, no mem_we, wr_ptr unchanged, in_ready stays 0.
- Overflow: BASE_ADDR=1015, irmovq -> bad_mem=1, no writes. BASE_ADDR=1014, irmovq -> writes 1014..1023, bad_mem=0.
- Reset at 4th byte of irmovq -> all outputs at reset values immediately; after release an addq writes at BASE_ADDR.
- With ENCODER_CHECKSUM_EN: irmovq val_c=0x10, rb=2, ra=F -> checksum=0x32 (0x30+0xF2+0x10, mod 256).

Source files
------------

// File: rtl/y86_instr_encoder.sv
// Serialises decoded Y86 instruction fields into byte-wide instruction memory, one byte per cycle.
// Optional running byte checksum output enabled by defining ENCODER_CHECKSUM_EN.
module y86_instr_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_code,
  input  logic [3:0]        in_fun,
  input  logic [3:0]        ra,
  input  logic [3:0]        rb,
  input  logic [63:0]       val_c,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [15:0]       instr_count,
  output logic              in_error,
  output logic              bad_mem,
  output logic              flag_halt
`ifdef ENCODER_CHECKSUM_EN
  ,output logic [7:0]       checksum
`endif
);

  // Pointer carries one extra bit so a completely full memory is distinguishable from empty.
  localparam int unsigned PTR_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, EMIT, STOP} state_t;

  function automatic logic [3:0] instr_len(input logic [3:0] code);
    case (code)
      4'd0, 4'd1, 4'd9:          instr_len = 4'd1;
      4'd2, 4'd6, 4'd10, 4'd11:  instr_len = 4'd2;
      4'd3, 4'd4, 4'd5:          instr_len = 4'd10;
      4'd7, 4'd8:                instr_len = 4'd9;
      default:                   instr_len = 4'd1;
    endcase
  endfunction

  state_t             r_state, w_state_nxt;
  logic               r_in_ready, w_in_ready_nxt;
  logic               r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0]  r_mem_addr, w_mem_addr_nxt;
  logic [7:0]         r_mem_wdata, w_mem_wdata_nxt;
  logic [PTR_W-1:0]   r_wr_ptr, w_wr_ptr_nxt;
  logic [15:0]        r_instr_count, w_instr_count_nxt;
  logic               r_in_error, w_in_error_nxt;
  logic               r_bad_mem, w_bad_mem_nxt;
  logic               r_flag_halt, w_flag_halt_nxt;
  logic [3:0]         r_code, w_code_nxt;
  logic [3:0]         r_fun, w_fun_nxt;
  logic [3:0]         r_ra, w_ra_nxt;
  logic [3:0]         r_rb, w_rb_nxt;
  logic [63:0]        r_valc, w_valc_nxt;
  logic [3:0]         r_len, w_len_nxt;
  logic [3:0]         r_k, w_k_nxt;

  logic [3:0]         w_len;
  logic [PTR_W-1:0]   w_end;
  logic [63:0]        w_shift;
  logic [7:0]         w_byte;

  assign w_len = instr_len(in_code);
  assign w_end = r_wr_ptr + PTR_W'(w_len);

  // Byte k (k >= 1) of the latched instruction; constants go out most-significant byte first.
  always_comb begin
    w_shift = '0;
    w_byte  = {r_code, r_fun};
    if (r_len == 4'd9) begin
      w_shift = r_valc >> {4'd8 - r_k, 3'b000};
      w_byte  = w_shift[7:0];
    end else if (r_k == 4'd1) begin
      w_byte  = {r_ra, r_rb};
    end else begin
      w_shift = r_valc >> {4'd9 - r_k, 3'b000};
      w_byte  = w_shift[7:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_in_ready    <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_wr_ptr      <= PTR_W'(BASE_ADDR);
      r_instr_count <= '0;
      r_in_error    <= 1'b0;
      r_bad_mem     <= 1'b0;
      r_flag_halt   <= 1'b0;
      r_code        <= '0;
      r_fun         <= '0;
      r_ra          <= '0;
      r_rb          <= '0;
      r_valc        <= '0;
      r_len         <= '0;
      r_k           <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_in_ready    <= w_in_ready_nxt;
      r_mem_we      <= w_mem_we_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_instr_count <= w_instr_count_nxt;
      r_in_error    <= w_in_error_nxt;
      r_bad_mem     <= w_bad_mem_nxt;
      r_flag_halt   <= w_flag_halt_nxt;
      r_code        <= w_code_nxt;
      r_fun         <= w_fun_nxt;
      r_ra          <= w_ra_nxt;
      r_rb          <= w_rb_nxt;
      r_valc        <= w_valc_nxt;
      r_len         <= w_len_nxt;
      r_k           <= w_k_nxt;
    end
  end

  // Byte 0 is emitted on the accept edge; EMIT sends the rest, then commits pointer and count.
  always_comb begin
    w_state_nxt       = r_state;
    w_in_ready_nxt    = 1'b0;
    w_mem_we_nxt      = 1'b0;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_wdata_nxt   = r_mem_wdata;
    w_wr_ptr_nxt      = r_wr_ptr;
    w_instr_count_nxt = r_instr_count;
    w_in_error_nxt    = r_in_error;
    w_bad_mem_nxt     = r_bad_mem;
    w_flag_halt_nxt   = r_flag_halt;
    w_code_nxt        = r_code;
    w_fun_nxt         = r_fun;
    w_ra_nxt          = r_ra;
    w_rb_nxt          = r_rb;
    w_valc_nxt        = r_valc;
    w_len_nxt         = r_len;
    w_k_nxt           = r_k;
    case (r_state)
      IDLE: begin
        w_in_ready_nxt = 1'b1;
        if (in_valid && r_in_ready) begin
          w_in_ready_nxt = 1'b0;
          w_code_nxt     = in_code;
          w_fun_nxt      = in_fun;
          w_ra_nxt       = ra;
          w_rb_nxt       = rb;
          w_valc_nxt     = val_c;
          w_len_nxt      = w_len;
          if (in_code > 4'd11) begin
            w_in_error_nxt = 1'b1;
            w_state_nxt    = STOP;
          end else if (w_end > PTR_W'(MEM_DEPTH)) begin
            w_bad_mem_nxt  = 1'b1;
            w_state_nxt    = STOP;
          end else begin
            w_mem_we_nxt    = 1'b1;
            w_mem_addr_nxt  = r_wr_ptr[ADDR_W-1:0];
            w_mem_wdata_nxt = {in_code, in_fun};
            w_k_nxt         = 4'd1;
            w_state_nxt     = EMIT;
          end
        end
      end
      EMIT: begin
        if (r_k < r_len) begin
          w_mem_we_nxt    = 1'b1;
          w_mem_addr_nxt  = r_wr_ptr[ADDR_W-1:0] + ADDR_W'(r_k);
          w_mem_wdata_nxt = w_byte;
          w_k_nxt         = r_k + 4'd1;
        end else begin
          w_wr_ptr_nxt      = r_wr_ptr + PTR_W'(r_len);
          w_instr_count_nxt = r_instr_count + 16'd1;
          if (r_code == 4'd0) begin
            w_flag_halt_nxt = 1'b1;
            w_state_nxt     = STOP;
          end else begin
            w_in_ready_nxt  = 1'b1;
            w_state_nxt     = IDLE;
          end
        end
      end
      STOP: w_state_nxt = STOP;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign in_ready    = r_in_ready;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign wr_ptr      = r_wr_ptr[ADDR_W-1:0];
  assign instr_count = r_instr_count;
  assign in_error    = r_in_error;
  assign bad_mem     = r_bad_mem;
  assign flag_halt   = r_flag_halt;

`ifdef ENCODER_CHECKSUM_EN
  logic [7:0] r_checksum;

  // Running modulo-256 sum of every byte that left on the write port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      r_checksum <= '0;
    else if (r_mem_we) r_checksum <= r_checksum + r_mem_wdata;
  end

  assign checksum = r_checksum;
`endif

endmodule
